combo_lock_param: RTL



---
 rtl/combo_lock_param.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/combo_lock_param.sv
// combo_lock_param: parametrised digit combination lock with reprogramming, timed lockout
// and six active-low 7-segment status displays.
module combo_lock_param #(
  parameter int CODE_LEN = 6,
  parameter logic [CODE_LEN*4-1:0] INIT_CODE = 24'h511748,
  parameter int MAX_FAILS = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic digit_valid,
  input  logic [3:0] digit,
  input  logic clear,
  input  logic prog,
  output logic unlocked,
  output logic locked_out,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5
);
  localparam int W = CODE_LEN * 4;
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int TW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [6:0] BLANK = 7'h7F;
  typedef enum logic [2:0] {ENTER, OPEN, CLOSED, LOCKOUT, PROG} state_t;
  state_t state, state_d;
  logic [2:0] idx;
  logic bad, last_vld, ill, miss, last_dig;
  logic [W-1:0] code, shadow;
  logic [TW-1:0] timer;
  logic [3:0] last, nib;
  logic [FW-1:0] fail_inc;
  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h18;
      default: seg = 7'h2F;
    endcase
  endfunction
  // First code digit lives in the most significant nibble.
  always_comb begin
    nib = 4'(code >> (4 * (CODE_LEN - 1 - int'(idx))));
    ill = digit > 4'd9;
    miss = bad || ill || digit != nib;
    last_dig = int'(idx) == CODE_LEN - 1;
    fail_inc = fail_cnt == FW'(MAX_FAILS) ? fail_cnt : fail_cnt + FW'(1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ENTER;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      ENTER: if (!clear && digit_valid && last_dig)
        state_d = !miss ? OPEN : fail_inc == FW'(MAX_FAILS) ? LOCKOUT : CLOSED;
      CLOSED: if (clear) state_d = ENTER;
      OPEN: state_d = clear ? ENTER : prog ? PROG : OPEN;
      PROG: if (clear || (digit_valid && ill)) state_d = OPEN;
        else if (digit_valid && last_dig) state_d = ENTER;
      LOCKOUT: if (timer == TW'(1)) state_d = ENTER;
      default: state_d = ENTER;
    endcase
  end
  // Any state change or clear starts the next view with an empty last-digit display.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx <= '0;
      bad <= 1'b0;
      code <= INIT_CODE;
      shadow <= '0;
      timer <= '0;
      last <= '0;
      last_vld <= 1'b0;
      fail_cnt <= '0;
    end else begin
      if (clear || state_d != state) last_vld <= 1'b0;
      case (state)
        ENTER:
          if (clear) begin
            idx <= '0;
            bad <= 1'b0;
          end else if (digit_valid) begin
            last <= digit;
            last_vld <= !last_dig;
            idx <= last_dig ? '0 : idx + 3'd1;
            bad <= !last_dig && miss;
            if (last_dig) fail_cnt <= miss ? fail_inc : '0;
            if (state_d == LOCKOUT) timer <= TW'(LOCKOUT_CYCLES);
          end
        OPEN: if (prog) idx <= '0;
        PROG:
          if (clear || (digit_valid && ill)) idx <= '0;
          else if (digit_valid) begin
            shadow <= W'({shadow, digit});
            last <= digit;
            last_vld <= !last_dig;
            idx <= last_dig ? '0 : idx + 3'd1;
            if (last_dig) code <= W'({shadow, digit});
          end
        LOCKOUT: begin
          timer <= timer - TW'(1);
          if (state_d == ENTER) fail_cnt <= '0;
        end
        default: ;
      endcase
    end
  always_comb begin
    {hex5, hex4, hex3, hex2, hex1, hex0} = {6{BLANK}};
    unlocked = state == OPEN;
    locked_out = state == LOCKOUT;
    case (state)
      ENTER: begin
        hex0 = last_vld ? seg(last) : BLANK;
        hex5 = seg({1'b0, idx});
      end
      OPEN: {hex3, hex2, hex1, hex0} = {7'h40, 7'h0C, 7'h06, 7'h48};
      CLOSED: {hex5, hex4, hex3, hex2, hex1, hex0} = {7'h46, 7'h47, 7'h40, 7'h12, 7'h06, 7'h21};
      LOCKOUT: begin
        {hex5, hex4, hex3} = {7'h47, 7'h40, 7'h46};
        hex0 = seg(4'(fail_cnt));
      end
      PROG: begin
        {hex5, hex4} = {7'h0C, 7'h2F};
        hex1 = seg({1'b0, idx});
        hex0 = last_vld ? seg(last) : BLANK;
      end
      default: ;
    endcase
  end
endmodule
